// File: rtl/evtx_gea0_pkg.sv
// Shared types and constants for the evtx_gea0 event-capture stage.
`include "evtx_defs.vh"

package evtx_gea0_pkg;
   localparam int   SIZE_DEF  = `EVTX_SIZE_DEF;
   localparam int   CNT_W_DEF = `EVTX_CNT_W_DEF;
   localparam logic PEND_RST  = `EVTX_PEND_RST;
   localparam int   CNT_RST   = `EVTX_CNT_RST;

   // Per-line capture state held by each bit slice.
   typedef struct packed {
      logic ev;
      logic pend;
      logic ovf;
   } bit_st_t;

   localparam bit_st_t BIT_ST_RST = '{ev: 1'b0, pend: PEND_RST, ovf: PEND_RST};
endpackage

// File: rtl/evtx_gea0_if.sv
// Event/status bundle between the register-map side and the capture stage.
interface evtx_gea0_if
   import evtx_gea0_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic [SIZE-1:0]  ev_i;
   logic [SIZE-1:0]  mask_i;
   logic [SIZE-1:0]  clr_i;
   logic [CNT_W-1:0] holdoff_i;
   logic [SIZE-1:0]  pend_o;
   logic [SIZE-1:0]  ovf_o;
   logic [SIZE-1:0]  act_o;
   logic             hold_o;

   modport master (
      output ev_i, mask_i, clr_i, holdoff_i,
      input  pend_o, ovf_o, act_o, hold_o
   );

   modport slave (
      input  ev_i, mask_i, clr_i, holdoff_i,
      output pend_o, ovf_o, act_o, hold_o
   );
endinterface

// File: rtl/evtx_bit_gea0.sv
// One event line: edge detect, sticky pending and overflow with W1C clear.
module evtx_bit_gea0
   import evtx_gea0_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ev_i,
   input  logic clr_i,
   output logic pend_o,
   output logic ovf_o
);
   bit_st_t st_q, st_d;
   logic    edge_s;

   assign edge_s = ev_i & ~st_q.ev;

   // A new edge beats a same-cycle clear so no event is ever lost; that edge
   // counts as fresh, not as an overflow.
   always_comb begin
      st_d      = st_q;
      st_d.ev   = ev_i;
      st_d.pend = edge_s | (st_q.pend & ~clr_i);
      st_d.ovf  = (edge_s & st_q.pend & ~clr_i) | (st_q.ovf & ~clr_i);
   end

   always_ff @(posedge clk) begin
      if (rst) st_q <= BIT_ST_RST;
      else     st_q <= st_d;
   end

   assign pend_o = st_q.pend;
   assign ovf_o  = st_q.ovf;
endmodule

// File: rtl/evtx_defs.vh
// Reset constants and default parameter values for the evtx event-capture
// family, shared with the register-map wrapper.
`ifndef EVTX_DEFS_VH
`define EVTX_DEFS_VH
`define EVTX_PEND_RST 1'b0
`define EVTX_CNT_RST  0
`define EVTX_SIZE_DEF 2
`define EVTX_CNT_W_DEF 4
`endif

// File: rtl/evtx_gea0.sv
// Event capture stage: SIZE bit slices plus shared post-clear holdoff and
// act_o gating toward the downstream OR-reduction cell.
module evtx_gea0
   import evtx_gea0_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic        clk,
   input  logic        rst,
   evtx_gea0_if.slave  bus
);
   logic [SIZE-1:0]  pend_s, ovf_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_s;

   for (genvar i = 0; i < SIZE; i++) begin : g_bit
      evtx_bit_gea0 u_bit (
         .clk    (clk),
         .rst    (rst),
         .ev_i   (bus.ev_i[i]),
         .clr_i  (bus.clr_i[i]),
         .pend_o (pend_s[i]),
         .ovf_o  (ovf_s[i])
      );
   end

   // Any clear (even of a non-pending bit) reloads the window; never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (|bus.clr_i)        cnt_d = bus.holdoff_i;
      else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= CNT_W'(CNT_RST);
      else     cnt_q <= cnt_d;
   end

   assign hold_s      = (cnt_q != '0);
   assign bus.hold_o  = hold_s;
   assign bus.pend_o  = pend_s;
   assign bus.ovf_o   = ovf_s;
   assign bus.act_o   = hold_s ? '0 : (pend_s & bus.mask_i);
endmodule

// File: tb/tb_evtx_gea0.sv
// Randomized and directed checks of evtx_gea0 against a cycle-level model.
module tb_evtx_gea0;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   evtx_gea0_if #(.SIZE(2), .CNT_W(4)) bus ();

   evtx_gea0 #(.SIZE(2), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference state: previous level, pending, overflow per line, holdoff count.
   logic [1:0] m_prev, m_pend, m_ovf;
   int         m_cnt;

   function automatic logic [1:0] exp_act();
      return (m_cnt > 0) ? 2'b00 : (m_pend & bus.mask_i);
   endfunction

   // Advance the model with the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic [1:0] np, no;
      int nc;
      np = m_pend; no = m_ovf; nc = m_cnt;
      if (rst) begin
         np = 0; no = 0; nc = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit rose;
            rose  = bus.ev_i[i] && !m_prev[i];
            no[i] = bus.clr_i[i] ? 1'b0 : (m_ovf[i] | (rose & m_pend[i]));
            np[i] = rose ? 1'b1 : (bus.clr_i[i] ? 1'b0 : m_pend[i]);
         end
         if (bus.clr_i != 0) nc = int'(bus.holdoff_i);
         else if (nc > 0)    nc = nc - 1;
      end
      @(posedge clk);
      m_prev = rst ? 2'b00 : bus.ev_i;
      m_pend = np; m_ovf = no; m_cnt = nc;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ev_i = 0; bus.clr_i = 0; bus.mask_i = 2'b11; bus.holdoff_i = 0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ev_i = 2'b11; bus.clr_i = 0; bus.mask_i = 2'b11; bus.holdoff_i = 4'd5;
      tick(); tick();
      n_tests++;
      if (bus.pend_o !== 2'b00 || bus.ovf_o !== 2'b00 || bus.act_o !== 2'b00 || bus.hold_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: pend=%b ovf=%b act=%b hold=%b, want all 0", bus.pend_o, bus.ovf_o, bus.act_o, bus.hold_o);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.pend_o !== 2'b11 || bus.ovf_o !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release_edge: pend=%b ovf=%b, want pend=11 ovf=00", bus.pend_o, bus.ovf_o);
      end
   endtask

   task automatic test_edge_level();
      do_reset();
      bus.ev_i = 2'b01;
      tick();
      n_tests++;
      if (bus.pend_o !== 2'b01) begin
         n_fail++;
         $display("FAIL edge_latency: pend=%b want 01", bus.pend_o);
      end
      tick();
      bus.clr_i = 2'b01;
      tick();
      bus.clr_i = 2'b00;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (bus.pend_o !== 2'b00) begin
            n_fail++;
            $display("FAIL level_no_retrigger[%0d]: pend=%b want 00", k, bus.pend_o);
         end
         tick();
      end
      bus.ev_i = 2'b00;
   endtask

   task automatic test_collision();
      do_reset();
      bus.ev_i = 2'b10; bus.clr_i = 2'b10;
      tick();
      bus.clr_i = 2'b00;
      n_tests++;
      if (bus.pend_o[1] !== 1'b1 || bus.ovf_o[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL set_beats_clear: pend=%b ovf=%b want pend[1]=1 ovf[1]=0", bus.pend_o, bus.ovf_o);
      end
      bus.ev_i = 2'b00; tick();
      bus.ev_i = 2'b10; tick();
      n_tests++;
      if (bus.ovf_o !== 2'b10 || bus.pend_o !== 2'b10) begin
         n_fail++;
         $display("FAIL overflow_set: ovf=%b pend=%b want ovf=10 pend=10", bus.ovf_o, bus.pend_o);
      end
      bus.clr_i = 2'b10; tick();
      bus.clr_i = 2'b00;
      n_tests++;
      if (bus.ovf_o !== 2'b00 || bus.pend_o !== 2'b00) begin
         n_fail++;
         $display("FAIL clear_both: ovf=%b pend=%b want 00/00", bus.ovf_o, bus.pend_o);
      end
      bus.ev_i = 2'b00;
   endtask

   task automatic test_holdoff();
      do_reset();
      bus.holdoff_i = 4'd3; bus.mask_i = 2'b11;
      bus.ev_i = 2'b11; tick();
      bus.ev_i = 2'b00;
      #1;
      n_tests++;
      if (bus.act_o !== 2'b11 || bus.hold_o !== 1'b0) begin
         n_fail++;
         $display("FAIL act_before_clear: act=%b hold=%b want 11/0", bus.act_o, bus.hold_o);
      end
      for (int rep = 0; rep < 2; rep++) begin
         bus.clr_i = 2'b01; tick();
         bus.clr_i = 2'b00;
         if (rep == 1) begin
            // reload mid-window: clear again after one cycle of holdoff
            tick();
            bus.clr_i = 2'b01; tick();
            bus.clr_i = 2'b00;
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.act_o !== 2'b00 || bus.hold_o !== 1'b1) begin
               n_fail++;
               $display("FAIL holdoff_window[%0d,%0d]: act=%b hold=%b want 00/1", rep, k, bus.act_o, bus.hold_o);
            end
            tick();
         end
         n_tests++;
         if (bus.act_o !== 2'b10 || bus.hold_o !== 1'b0) begin
            n_fail++;
            $display("FAIL holdoff_end[%0d]: act=%b hold=%b want 10/0", rep, bus.act_o, bus.hold_o);
         end
      end
      bus.holdoff_i = 0;
   endtask

   task automatic test_mask();
      logic [1:0] seq [3] = '{2'b01, 2'b00, 2'b01};
      do_reset();
      bus.ev_i = 2'b01; tick();
      bus.ev_i = 2'b00;
      foreach (seq[k]) begin
         bus.mask_i = seq[k];
         #1;
         n_tests++;
         if (bus.act_o !== seq[k] || bus.pend_o !== 2'b01) begin
            n_fail++;
            $display("FAIL mask_same_cycle[%0d]: act=%b pend=%b want act=%b pend=01", k, bus.act_o, bus.pend_o, seq[k]);
         end
      end
      bus.mask_i = 2'b11;
   endtask

   task automatic test_rst_holdoff();
      do_reset();
      bus.holdoff_i = 4'd15;
      bus.ev_i = 2'b11; tick();
      bus.clr_i = 2'b01; tick();
      bus.clr_i = 2'b00; bus.ev_i = 2'b00;
      tick(); tick();
      rst = 1'b1; tick();
      n_tests++;
      if (bus.pend_o !== 2'b00 || bus.ovf_o !== 2'b00 || bus.act_o !== 2'b00 || bus.hold_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_holdoff: pend=%b ovf=%b act=%b hold=%b want all 0", bus.pend_o, bus.ovf_o, bus.act_o, bus.hold_o);
      end
      rst = 1'b0; bus.holdoff_i = 0;
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst           = ($urandom_range(0, 49) == 0);
         bus.ev_i      = 2'($urandom);
         bus.clr_i     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         bus.mask_i    = 2'($urandom);
         bus.holdoff_i = 4'($urandom_range(0, 5));
         #1;
         n_tests++;
         if (bus.act_o !== exp_act() || bus.hold_o !== (m_cnt > 0) ||
             bus.pend_o !== m_pend || bus.ovf_o !== m_ovf) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL random[%0d]: pend=%b/%b ovf=%b/%b act=%b/%b hold=%b/%b (got/want)", c,
                        bus.pend_o, m_pend, bus.ovf_o, m_ovf, bus.act_o, exp_act(), bus.hold_o, (m_cnt > 0));
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      m_prev = 0; m_pend = 0; m_ovf = 0; m_cnt = 0;
      test_reset();
      test_edge_level();
      test_collision();
      test_holdoff();
      test_mask();
      test_rst_holdoff();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
